// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: one request at a time, alignment check,
// req/gnt/rvalid bus handshake with optional timeout, extended load return.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        ls_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        rsp_err_code,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt;

  logic        in_byte, in_half, in_word, misaligned;
  logic        op_byte, op_half, op_store, op_signed;
  logic        load_done, store_done, done, timeout;
  logic [31:0] lane, load_ext;
  logic        accept;

  // Incoming request decode (used only for the alignment decision in IDLE)
  always_comb begin
    in_byte    = (ls_ctrl == 3'b000) || (ls_ctrl == 3'b011) || (ls_ctrl == 3'b101);
    in_half    = (ls_ctrl == 3'b001) || (ls_ctrl == 3'b100) || (ls_ctrl == 3'b110);
    in_word    = !in_byte && !in_half;
    misaligned = (in_half && req_addr[0]) || (in_word && (req_addr[1:0] != 2'b00));
  end

  // Latched operation decode
  always_comb begin
    op_byte   = (op_q == 3'b000) || (op_q == 3'b011) || (op_q == 3'b101);
    op_half   = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    op_store  = op_q[2] && (op_q[1:0] != 2'b00);
    op_signed = (op_q == 3'b000) || (op_q == 3'b001);
  end

  // A load may complete in the grant cycle if rvalid arrives alongside gnt
  always_comb begin
    store_done = (state == REQ) && mem_gnt && op_store;
    load_done  = ((state == REQ) && mem_gnt && !op_store && mem_rvalid) ||
                 ((state == WAIT) && mem_rvalid);
    done       = store_done || load_done;
    timeout    = (TIMEOUT_CYCLES != 0) && ((state == REQ) || (state == WAIT)) &&
                 (cnt == CNT_LAST) && !done;
    accept     = (state == IDLE) && req_valid;
  end

  always_comb begin
    lane     = mem_rdata >> {addr_q[1:0], 3'b000};
    load_ext = lane;
    if (op_byte)
      load_ext = {{24{op_signed & lane[7]}}, lane[7:0]};
    else if (op_half)
      load_ext = {{16{op_signed & lane[15]}}, lane[15:0]};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_valid) state_nxt = misaligned ? RESP : REQ;
      REQ: begin
        if (done || timeout)    state_nxt = RESP;
        else if (mem_gnt)       state_nxt = WAIT;
      end
      WAIT: if (done || timeout) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt          <= '0;
      rsp_rdata    <= '0;
      rsp_err_code <= ERR_NONE;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= ls_ctrl;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= '0;
        if (misaligned) begin
          rsp_rdata    <= '0;
          rsp_err_code <= ERR_ALIGN;
        end
      end else if ((state == REQ) || (state == WAIT)) begin
        cnt <= cnt + 1'b1;
        if (load_done) begin
          rsp_rdata    <= load_ext;
          rsp_err_code <= ERR_NONE;
        end else if (store_done) begin
          rsp_rdata    <= '0;
          rsp_err_code <= ERR_NONE;
        end else if (timeout) begin
          rsp_rdata    <= '0;
          rsp_err_code <= ERR_TMO;
        end
      end
    end
  end

  // Bus outputs are a pure function of the latched request while in REQ
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_err   = (rsp_err_code != ERR_NONE);
    mem_req   = (state == REQ);
    mem_we    = '0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (state == REQ) begin
      mem_we   = op_store;
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      if (op_byte) begin
        mem_be    = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{wdata_q[7:0]}};
      end else if (op_half) begin
        mem_be    = 4'b0011 << addr_q[1:0];
        mem_wdata = {2{wdata_q[15:0]}};
      end else begin
        mem_be    = 4'b1111;
        mem_wdata = wdata_q;
      end
    end
  end

endmodule
